key_line_printer: RTL and testbench
===================================

# key_line_printer

Line-oriented front/back end for the byte-reversal ROM stage.
- Upstream: collects `NUM_BYTES` keystrokes from the UART receiver into a packed word, which drives the ROM's 24-bit input.
- Downstream: walks the ROM addresses `0..MSG_LEN-1` and streams each returned byte to the UART transmitter under `tx_busy` flow control.
- It then returns to collecting the next line.

## Interface
- `NUM_BYTES`, 3: keystrokes per line; `bits_out` width is `8*NUM_BYTES`.
- `MSG_LEN`, 5: ROM entries sent per line (3 payload bytes + `"\n"` + `"\r"`); must be ≤ 8.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `rx_data`, in, 8: received byte from the UART receiver.
- `new_rx_data`, in, 1: one-cycle strobe; `rx_data` is valid this cycle.
- `bits_out`, out, 24: packed line to the ROM. Byte k occupies `[8k+7:8k]`; first keystroke goes in `[7:0]`.
- `addr`, out, 3: ROM address.
- `rom_data`, in, 8: ROM output, registered in the ROM. Valid one cycle after `addr` changes.
- `tx_data`, out, 8: byte to the UART transmitter.
- `new_tx_data`, out, 1: one-cycle strobe; `tx_data` is valid this cycle.
- `tx_busy`, in, 1: transmitter busy. Must rise no later than the cycle after `new_tx_data`.
- `busy`, out, 1: high while a line is being printed.
- `overrun`, out, 1: sticky flag, set when a keystroke is dropped.

## Operation
- The FSM has three states: `COLLECT`, `FETCH`, `SEND`. Reset state is `COLLECT`, with byte counter 0 and all outputs 0.
- `COLLECT`:
  - On `new_rx_data`, write `rx_data` into `bits_out` byte `[cnt]` and increment `cnt`.
  - When the byte written is the last one (`cnt==NUM_BYTES-1`):
    - clear `cnt` to 0;
    - set `addr` to 0;
    - go to `FETCH`.
  - `bits_out` is held between writes. Bytes of the previous line stay until overwritten.
- `FETCH`: wait exactly one cycle for `rom_data` to become valid for the current `addr`, then go to `SEND`.
- `SEND`:
  - While `tx_busy`=1: stay in `SEND`; `new_tx_data` stays 0.
  - When `tx_busy`=0:
    - set `tx_data` to `rom_data` and pulse `new_tx_data` for one cycle;
    - if `addr==MSG_LEN-1`: set `addr` to 0, go to `COLLECT`;
    - otherwise: increment `addr`, go to `FETCH`.
- `busy`=1 exactly while the state is `FETCH` or `SEND`.
- `new_rx_data` while `busy`=1:
  - the byte is discarded;
  - `bits_out` and `cnt` are unchanged;
  - `overrun` is set to 1.
- `overrun` is cleared only by `rst`.
- `addr` never exceeds `MSG_LEN-1`. `cnt` never exceeds `NUM_BYTES-1`.
- `rst` asserted mid-line, in any state:
  - next edge restores all reset values;
  - a partially collected line and an in-progress print are abandoned;
  - `new_tx_data` is forced to 0 that cycle.

## Timing
- `bits_out` updates on the edge after `new_rx_data`.
- The third keystroke is sampled at edge E:
  - `busy`=1 and `addr`=0 from E;
  - the first `new_tx_data` is at E+1 at the earliest, when `tx_busy`=0.
- Per-byte minimum period: 2 cycles (`FETCH` + `SEND`) plus the time `tx_busy` is high.
- A line of 5 bytes issues exactly 5 `new_tx_data` pulses, in `addr` order 0,1,2,3,4.
- `tx_data` is registered and holds its value after the strobe.
- `new_tx_data` is never high on two consecutive cycles.
- Simultaneous `new_rx_data` on the cycle the last byte is sent (`SEND`→`COLLECT` transition): the byte is dropped and `overrun` is set. Collection starts the following cycle.
- `tx_busy` is sampled only in `SEND`.

## Test plan
All scenarios use a byte-reversing ROM model with 1-cycle latency.
1. Reset → verify all reset values:
   - outputs: `bits_out`=0, `addr`=0, `new_tx_data`=0, `busy`=0, `overrun`=0;
   - internal: state `COLLECT`, `cnt`=0.
2. Keys `"a"`,`"b"`,`"c"`, with `tx_busy` tied 0:
   - `bits_out`=24'h636261;
   - tx stream `"c"`,`"b"`,`"a"`,`8'h0A`,`8'h0D`;
   - strobes 2 cycles apart;
   - `busy` drops after the 5th strobe.
3. Transmitter model holds `tx_busy` high for 10 cycles after each strobe:
   - each strobe follows `tx_busy` falling by ≤2 cycles;
   - byte order is unchanged;
   - no strobe occurs while `tx_busy`=1.
4. Key `"x"` injected while printing line `"abc"`:
   - `overrun`=1;
   - `bits_out` unchanged;
   - the next line `"def"` prints `"f"`,`"e"`,`"d"`,`\n`,`\r`.
5. `rst` asserted after key 2, and again after the 2nd tx strobe:
   - registers return to reset values next edge;
   - no further strobes;
   - a fresh `"xyz"` prints `"z"`,`"y"`,`"x"`,`\n`,`\r`.
6. Two back-to-back lines `"123"` then `"456"`, keys spaced 100 cycles:
   - 10 strobes total;
   - second line's `bits_out`=24'h363534.

Source files
------------

// File: rtl/key_line_printer.sv
// Collects NUM_BYTES keystrokes into a packed word for the ROM, then streams
// ROM entries 0..MSG_LEN-1 to the UART transmitter under tx_busy flow control.
module key_line_printer #(
  parameter int NUM_BYTES = 3,
  parameter int MSG_LEN   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   new_rx_data,
  output logic [8*NUM_BYTES-1:0] bits_out,
  output logic [2:0]             addr,
  input  logic [7:0]             rom_data,
  output logic [7:0]             tx_data,
  output logic                   new_tx_data,
  input  logic                   tx_busy,
  output logic                   busy,
  output logic                   overrun
);

  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FETCH   = 2'd1,
    SEND    = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_addr;
  logic [7:0]             r_tx_data;
  logic [8*NUM_BYTES-1:0] r_bits;
  logic                   r_overrun;

  logic w_key_accept;
  logic w_key_drop;
  logic w_last_key;
  logic w_last_addr;
  logic w_send;

  assign w_last_key  = (r_cnt == CW'(NUM_BYTES - 1));
  assign w_last_addr = (r_addr == 3'(MSG_LEN - 1));
  // Keys arriving outside COLLECT, including the SEND->COLLECT cycle, are lost.
  assign w_key_drop  = new_rx_data && (r_state != COLLECT);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_key_accept = 1'b0;
    w_send       = 1'b0;
    case (r_state)
      COLLECT: begin
        if (new_rx_data) begin
          w_key_accept = 1'b1;
          if (w_last_key) w_next_state = FETCH;
        end
      end
      FETCH:   w_next_state = SEND;
      SEND: begin
        if (!tx_busy) begin
          w_send       = 1'b1;
          w_next_state = w_last_addr ? COLLECT : FETCH;
        end
      end
      default: w_next_state = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= COLLECT;
    else     r_state <= w_next_state;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_addr    <= '0;
      r_tx_data <= '0;
      r_bits    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_key_accept) begin
        for (int k = 0; k < NUM_BYTES; k++) begin
          if (r_cnt == CW'(k)) r_bits[8*k +: 8] <= rx_data;
        end
        if (w_last_key) begin
          r_cnt  <= '0;
          r_addr <= '0;
        end else begin
          r_cnt  <= r_cnt + CW'(1);
        end
      end
      if (w_send) begin
        r_tx_data <= rom_data;
        r_addr    <= w_last_addr ? 3'd0 : r_addr + 3'd1;
      end
      if (w_key_drop) r_overrun <= 1'b1;
    end
  end

  // The strobe is masked by rst so an in-progress print emits nothing that cycle.
  assign new_tx_data = w_send && !rst;
  assign tx_data     = new_tx_data ? rom_data : r_tx_data;
  assign bits_out    = r_bits;
  assign addr        = r_addr;
  assign busy        = (r_state != COLLECT);
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_key_line_printer.sv
// Directed bench for key_line_printer with a byte-reversing 1-cycle ROM and a
// transmitter model that can hold tx_busy for a programmable number of cycles.
module tb_key_line_printer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        new_rx_data = 1'b0;
  logic [23:0] bits_out;
  logic [2:0]  addr;
  logic [7:0]  rom_data = 8'h00;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy = 1'b0;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int hold_cycles = 0;
  int busy_cnt = 0;

  logic [7:0] q[$];
  int         tq[$];
  int         busy_viol = 0;
  int         consec_viol = 0;
  int         gap_checks = 0;
  int         gap_viol = 0;
  int         last_fall = -1;
  logic       prev_strobe = 1'b0;
  logic       prev_busy = 1'b0;

  key_line_printer #(.NUM_BYTES(3), .MSG_LEN(5)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .bits_out(bits_out), .addr(addr), .rom_data(rom_data), .tx_data(tx_data),
    .new_tx_data(new_tx_data), .tx_busy(tx_busy), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-reversing ROM, registered output.
  always @(posedge clk) begin
    case (addr)
      3'd0:    rom_data <= bits_out[23:16];
      3'd1:    rom_data <= bits_out[15:8];
      3'd2:    rom_data <= bits_out[7:0];
      3'd3:    rom_data <= 8'h0A;
      3'd4:    rom_data <= 8'h0D;
      default: rom_data <= 8'h00;
    endcase
  end

  // Transmitter: busy for hold_cycles cycles after each strobe.
  always @(posedge clk) begin
    if (new_tx_data && hold_cycles > 0) begin
      tx_busy  <= 1'b1;
      busy_cnt <= hold_cycles;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) tx_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (prev_busy && !tx_busy) last_fall = cyc;
    if (new_tx_data) begin
      q.push_back(tx_data);
      tq.push_back(cyc);
      if (tx_busy) busy_viol++;
      if (prev_strobe) consec_viol++;
      if (hold_cycles > 0 && last_fall >= 0) begin
        gap_checks++;
        if (cyc - last_fall > 2) gap_viol++;
      end
    end
    prev_strobe = new_tx_data;
    prev_busy   = tx_busy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    q.delete();
    tq.delete();
    busy_viol   = 0;
    consec_viol = 0;
    gap_checks  = 0;
    gap_viol    = 0;
    last_fall   = -1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    new_rx_data = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_key(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    new_rx_data = 1'b1;
    @(negedge clk);
    new_rx_data = 1'b0;
  endtask

  task automatic wait_line(input int n, input int budget, input string name);
    int k = 0;
    while (q.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (q.size() < n) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d strobes, need %0d", name, q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    n_checks++; if (bits_out !== 24'h0) begin n_fail++; $display("FAIL reset bits_out: got %h exp 000000", bits_out); end
    n_checks++; if (addr !== 3'd0) begin n_fail++; $display("FAIL reset addr: got %0d exp 0", addr); end
    n_checks++; if (new_tx_data !== 1'b0) begin n_fail++; $display("FAIL reset new_tx_data: got %b exp 0", new_tx_data); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset tx_data: got %h exp 00", tx_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b exp 0", busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset overrun: got %b exp 0", overrun); end
    n_checks++; if (dut.r_state !== 2'd0) begin n_fail++; $display("FAIL reset state: got %0d exp 0", dut.r_state); end
    n_checks++; if (dut.r_cnt !== 2'd0) begin n_fail++; $display("FAIL reset cnt: got %0d exp 0", dut.r_cnt); end
  endtask

  task automatic test_basic();
    logic [7:0] exp [5] = '{8'h63, 8'h62, 8'h61, 8'h0A, 8'h0D};
    int e_cyc;
    hold_cycles = 0;
    clear_mon();
    send_key("a");
    send_key("b");
    send_key("c");
    e_cyc = cyc;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic busy after key3: got %b exp 1", busy); end
    n_checks++; if (addr !== 3'd0) begin n_fail++; $display("FAIL basic addr after key3: got %0d exp 0", addr); end
    n_checks++; if (bits_out !== 24'h636261) begin n_fail++; $display("FAIL basic bits_out: got %h exp 636261", bits_out); end
    wait_line(5, 40, "basic");
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (q.size() <= i || q[i] !== exp[i]) begin
        n_fail++; $display("FAIL basic byte%0d: got %h exp %h", i, (q.size() > i) ? q[i] : 8'hxx, exp[i]);
      end
    end
    n_checks++; if (tq.size() < 1 || tq[0] !== e_cyc + 1) begin n_fail++; $display("FAIL basic first strobe cycle: got %0d exp %0d", (tq.size() > 0) ? tq[0] : -1, e_cyc + 1); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tq.size() <= i + 1 || tq[i+1] - tq[i] !== 2) begin
        n_fail++; $display("FAIL basic strobe spacing%0d: got %0d exp 2", i, (tq.size() > i + 1) ? tq[i+1] - tq[i] : -1);
      end
    end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic busy after line: got %b exp 0", busy); end
    n_checks++; if (tx_data !== 8'h0D) begin n_fail++; $display("FAIL basic tx_data hold: got %h exp 0d", tx_data); end
    repeat (5) @(negedge clk);
    n_checks++; if (q.size() !== 5) begin n_fail++; $display("FAIL basic strobe count: got %0d exp 5", q.size()); end
    n_checks++; if (consec_viol !== 0) begin n_fail++; $display("FAIL basic consecutive strobes: got %0d exp 0", consec_viol); end
  endtask

  task automatic test_flow_control();
    logic [7:0] exp [5] = '{8'h63, 8'h62, 8'h61, 8'h0A, 8'h0D};
    hold_cycles = 10;
    clear_mon();
    send_key("a");
    send_key("b");
    send_key("c");
    wait_line(5, 200, "flow");
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (q.size() <= i || q[i] !== exp[i]) begin
        n_fail++; $display("FAIL flow byte%0d: got %h exp %h", i, (q.size() > i) ? q[i] : 8'hxx, exp[i]);
      end
    end
    n_checks++; if (busy_viol !== 0) begin n_fail++; $display("FAIL flow strobe while tx_busy: got %0d exp 0", busy_viol); end
    n_checks++; if (gap_checks !== 4) begin n_fail++; $display("FAIL flow falls observed: got %0d exp 4", gap_checks); end
    n_checks++; if (gap_viol !== 0) begin n_fail++; $display("FAIL flow late strobe after fall: got %0d exp 0", gap_viol); end
    n_checks++; if (tq.size() < 2 || tq[1] - tq[0] < 11) begin n_fail++; $display("FAIL flow spacing: got %0d exp >=11", (tq.size() > 1) ? tq[1] - tq[0] : -1); end
    hold_cycles = 0;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_overrun();
    logic [7:0] exp [5] = '{8'h66, 8'h65, 8'h64, 8'h0A, 8'h0D};
    hold_cycles = 0;
    clear_mon();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr before: got %b exp 0", overrun); end
    send_key("a");
    send_key("b");
    send_key("c");
    send_key("x");
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr flag: got %b exp 1", overrun); end
    n_checks++; if (bits_out !== 24'h636261) begin n_fail++; $display("FAIL ovr bits_out: got %h exp 636261", bits_out); end
    n_checks++; if (dut.r_cnt !== 2'd0) begin n_fail++; $display("FAIL ovr cnt: got %0d exp 0", dut.r_cnt); end
    wait_line(5, 40, "ovr_abc");
    repeat (4) @(negedge clk);
    clear_mon();
    send_key("d");
    send_key("e");
    send_key("f");
    wait_line(5, 40, "ovr_def");
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (q.size() <= i || q[i] !== exp[i]) begin
        n_fail++; $display("FAIL ovr def byte%0d: got %h exp %h", i, (q.size() > i) ? q[i] : 8'hxx, exp[i]);
      end
    end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr sticky: got %b exp 1", overrun); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_boundary_drop();
    int k = 0;
    reset_dut();
    hold_cycles = 0;
    clear_mon();
    send_key("a");
    send_key("b");
    send_key("c");
    while (!(new_tx_data && addr == 3'd4) && k < 40) begin
      @(negedge clk); #1; k++;
    end
    n_checks++; if (k >= 40) begin n_fail++; $display("FAIL bnd last strobe: not seen within %0d cycles", k); end
    rx_data = "q";
    new_rx_data = 1'b1;
    @(negedge clk);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL bnd overrun: got %b exp 1", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bnd busy: got %b exp 0", busy); end
    n_checks++; if (bits_out !== 24'h636261) begin n_fail++; $display("FAIL bnd bits_out: got %h exp 636261", bits_out); end
    n_checks++; if (q.size() !== 5) begin n_fail++; $display("FAIL bnd strobe count: got %0d exp 5", q.size()); end
    rx_data = "x";
    @(negedge clk);
    new_rx_data = 1'b0;
    n_checks++; if (dut.r_cnt !== 2'd1) begin n_fail++; $display("FAIL bnd cnt after x: got %0d exp 1", dut.r_cnt); end
    n_checks++; if (bits_out !== 24'h636278) begin n_fail++; $display("FAIL bnd bits after x: got %h exp 636278", bits_out); end
    send_key("y");
    send_key("z");
    n_checks++; if (bits_out !== 24'h7a7978) begin n_fail++; $display("FAIL bnd bits xyz: got %h exp 7a7978", bits_out); end
    repeat (15) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [5] = '{8'h7a, 8'h79, 8'h78, 8'h0A, 8'h0D};
    reset_dut();
    hold_cycles = 0;
    clear_mon();
    send_key("a");
    send_key("b");
    n_checks++; if (dut.r_cnt !== 2'd2 || bits_out !== 24'h006261) begin n_fail++; $display("FAIL rstmid partial: got cnt %0d bits %h exp 2 006261", dut.r_cnt, bits_out); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bits_out !== 24'h0 || dut.r_cnt !== 2'd0 || dut.r_state !== 2'd0) begin n_fail++; $display("FAIL rstmid collect: got bits %h cnt %0d state %0d exp 0 0 0", bits_out, dut.r_cnt, dut.r_state); end
    rst = 1'b0;
    send_key("a");
    send_key("b");
    send_key("c");
    wait_line(2, 40, "rstmid_two");
    rst = 1'b1;
    #1;
    n_checks++; if (new_tx_data !== 1'b0) begin n_fail++; $display("FAIL rstmid strobe masked: got %b exp 0", new_tx_data); end
    @(negedge clk);
    n_checks++; if (addr !== 3'd0 || busy !== 1'b0 || bits_out !== 24'h0) begin n_fail++; $display("FAIL rstmid send: got addr %0d busy %b bits %h exp 0 0 0", addr, busy, bits_out); end
    n_checks++; if (tx_data !== 8'h00 || overrun !== 1'b0 || dut.r_state !== 2'd0) begin n_fail++; $display("FAIL rstmid regs: got tx %h ovr %b state %0d exp 00 0 0", tx_data, overrun, dut.r_state); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (q.size() !== 2) begin n_fail++; $display("FAIL rstmid no more strobes: got %0d exp 2", q.size()); end
    clear_mon();
    send_key("x");
    send_key("y");
    send_key("z");
    wait_line(5, 40, "rstmid_xyz");
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (q.size() <= i || q[i] !== exp[i]) begin
        n_fail++; $display("FAIL rstmid xyz byte%0d: got %h exp %h", i, (q.size() > i) ? q[i] : 8'hxx, exp[i]);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [10] = '{8'h33, 8'h32, 8'h31, 8'h0A, 8'h0D,
                             8'h36, 8'h35, 8'h34, 8'h0A, 8'h0D};
    logic [7:0] keys [6] = '{"1", "2", "3", "4", "5", "6"};
    reset_dut();
    hold_cycles = 0;
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      send_key(keys[i]);
      repeat (100) @(negedge clk);
    end
    n_checks++; if (q.size() !== 10) begin n_fail++; $display("FAIL b2b strobe count: got %0d exp 10", q.size()); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (q.size() <= i || q[i] !== exp[i]) begin
        n_fail++; $display("FAIL b2b byte%0d: got %h exp %h", i, (q.size() > i) ? q[i] : 8'hxx, exp[i]);
      end
    end
    n_checks++; if (bits_out !== 24'h363534) begin n_fail++; $display("FAIL b2b bits_out: got %h exp 363534", bits_out); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b overrun: got %b exp 0", overrun); end
    n_checks++; if (consec_viol !== 0) begin n_fail++; $display("FAIL b2b consecutive strobes: got %0d exp 0", consec_viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flow_control();
    test_overrun();
    test_boundary_drop();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
